// File: rtl/lvds_rx_pattern_checker_if.sv
// Captured rx word and its valid qualifier, as handed from the IDDR capture stage to the checker.
// The producer drives the word and valid; the checker only observes them.
interface lvds_rx_pattern_checker_if #(
  parameter int W = 8
);
  logic [W-1:0] din;
  logic         din_valid;

  modport master (output din, output din_valid);
  modport slave  (input  din, input  din_valid);
endinterface

// File: rtl/lvds_rx_pattern_checker.sv
// LVDS rx link-test checker: self-synchronising pattern match, lock FSM with hysteresis, saturating stats.
// All outputs registered (1 cycle after the beat); no backpressure, din_valid=0 cycles are skipped.
module lvds_rx_pattern_checker #(
  parameter int LANES      = 4,
  parameter int CNT_W      = 32,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic [2*LANES-1:0]    fixed_pat,
  input  logic                  clr,
  lvds_rx_pattern_checker_if.slave rx,
  output logic                  locked,
  output logic                  error,
  output logic                  sticky_err,
  output logic [CNT_W-1:0]      word_cnt,
  output logic [CNT_W-1:0]      err_cnt,
  output logic [CNT_W-1:0]      bit_err_cnt,
  output logic [1:0]            state
);
  localparam int W  = 2 * LANES;
  localparam int PW = $clog2(W + 1);
  localparam int SW = CNT_W + PW;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [7:0]       LOCK_THR   = 8'(LOCK_CNT);
  localparam logic [7:0]       UNLOCK_THR = 8'(UNLOCK_CNT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEEK   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t         state_q;
  logic [W-1:0]   prev_q;
  logic           have_prev_q;
  logic [1:0]     mode_q;
  logic [7:0]     match_run_q;
  logic [7:0]     miss_run_q;

  logic [W-1:0]   exp_word;
  logic [W-1:0]   diff;
  logic [PW-1:0]  err_pop;
  logic           checkable;
  logic           mismatch;
  logic           mode_chg;
  logic [7:0]     match_run_inc;
  logic [7:0]     miss_run_inc;
  logic [CNT_W-1:0] word_inc;
  logic [CNT_W-1:0] err_inc;
  logic [SW-1:0]    bit_sum;
  logic [CNT_W-1:0] bit_nxt;

  assign state = state_q;

  // Expected word is predicted from the last valid word, so the checker locks onto any phase of the pattern.
  always_comb begin
    exp_word = fixed_pat;
    case (mode)
      2'd0:    exp_word = prev_q + W'(1);
      2'd1:    exp_word = (prev_q == '0) ? W'(1) : {prev_q[W-2:0], prev_q[W-1]};
      2'd2:    exp_word = ~prev_q;
      default: exp_word = fixed_pat;
    endcase
  end

  always_comb begin
    diff    = rx.din ^ exp_word;
    err_pop = '0;
    for (int i = 0; i < W; i++) begin
      err_pop = err_pop + PW'(diff[i]);
    end
  end

  assign checkable     = rx.din_valid && (have_prev_q || (mode == 2'd3));
  assign mismatch      = (diff != '0);
  assign mode_chg      = (mode != mode_q);
  assign match_run_inc = match_run_q + 8'd1;
  assign miss_run_inc  = miss_run_q + 8'd1;
  assign word_inc      = (word_cnt == CNT_MAX) ? word_cnt : word_cnt + CNT_W'(1);
  assign err_inc       = (err_cnt == CNT_MAX) ? err_cnt : err_cnt + CNT_W'(1);
  assign bit_sum       = SW'(bit_err_cnt) + SW'(err_pop);
  assign bit_nxt       = (bit_sum > SW'(CNT_MAX)) ? CNT_MAX : bit_sum[CNT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      locked      <= 1'b0;
      error       <= 1'b0;
      sticky_err  <= 1'b0;
      word_cnt    <= '0;
      err_cnt     <= '0;
      bit_err_cnt <= '0;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      mode_q      <= 2'd0;
      match_run_q <= '0;
      miss_run_q  <= '0;
    end else begin
      mode_q <= mode;
      if (!en) begin
        state_q     <= IDLE;
        locked      <= 1'b0;
        have_prev_q <= 1'b0;
        match_run_q <= '0;
        miss_run_q  <= '0;
      end else if (mode_chg) begin
        state_q     <= SEEK;
        locked      <= 1'b0;
        have_prev_q <= 1'b0;
        match_run_q <= '0;
        miss_run_q  <= '0;
      end else if (state_q == IDLE) begin
        state_q <= SEEK;
        locked  <= 1'b0;
      end else if (rx.din_valid) begin
        prev_q      <= rx.din;
        have_prev_q <= 1'b1;
        error       <= checkable && mismatch;
        if (checkable) begin
          if (state_q == SEEK) begin
            if (mismatch) begin
              match_run_q <= '0;
            end else if (match_run_inc >= LOCK_THR) begin
              state_q     <= LOCKED;
              locked      <= 1'b1;
              match_run_q <= '0;
              miss_run_q  <= '0;
            end else begin
              match_run_q <= match_run_inc;
            end
          end else begin
            word_cnt <= word_inc;
            if (mismatch) begin
              err_cnt     <= err_inc;
              bit_err_cnt <= bit_nxt;
              sticky_err  <= 1'b1;
              // The beat that trips the unlock still lands in the statistics above.
              if (miss_run_inc >= UNLOCK_THR) begin
                state_q     <= SEEK;
                locked      <= 1'b0;
                match_run_q <= '0;
                miss_run_q  <= '0;
              end else begin
                miss_run_q <= miss_run_inc;
              end
            end else begin
              miss_run_q <= '0;
            end
          end
        end
      end
      if (clr) begin
        word_cnt    <= '0;
        err_cnt     <= '0;
        bit_err_cnt <= '0;
        sticky_err  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_lvds_rx_pattern_checker.sv
// Directed bench for lvds_rx_pattern_checker: table-driven beats plus hand-written lock, gap, reset and saturation sequences.
module tb_lvds_rx_pattern_checker;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en1 = 1'b0, en2 = 1'b0;
  logic [1:0] mode1 = 2'd0, mode2 = 2'd3;
  logic       clr1 = 1'b0, clr2 = 1'b0;
  logic [7:0] fixed1 = 8'h00, fixed2 = 8'hA5;

  logic        locked1, error1, sticky1;
  logic [31:0] word1, errc1, bitc1;
  logic [1:0]  state1;
  logic        locked2, error2, sticky2;
  logic [3:0]  word2, errc2, bitc2;
  logic [1:0]  state2;

  int n_cmp = 0;
  int n_bad = 0;

  lvds_rx_pattern_checker_if #(.W(8)) rx1 ();
  lvds_rx_pattern_checker_if #(.W(8)) rx2 ();

  lvds_rx_pattern_checker #(.LANES(4), .CNT_W(32), .LOCK_CNT(16), .UNLOCK_CNT(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .mode(mode1), .fixed_pat(fixed1), .clr(clr1),
    .rx(rx1.slave), .locked(locked1), .error(error1), .sticky_err(sticky1),
    .word_cnt(word1), .err_cnt(errc1), .bit_err_cnt(bitc1), .state(state1)
  );

  lvds_rx_pattern_checker #(.LANES(4), .CNT_W(4), .LOCK_CNT(16), .UNLOCK_CNT(255)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .mode(mode2), .fixed_pat(fixed2), .clr(clr2),
    .rx(rx2.slave), .locked(locked2), .error(error2), .sticky_err(sticky2),
    .word_cnt(word2), .err_cnt(errc2), .bit_err_cnt(bitc2), .state(state2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  din;
    logic        exp_error;
    logic        exp_locked;
    logic [1:0]  exp_state;
    logic [31:0] exp_err_cnt;
    logic [31:0] exp_bit_cnt;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step1(input logic v, input logic [7:0] d);
    @(negedge clk);
    rx1.din_valid = v;
    rx1.din       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic step2(input logic v, input logic [7:0] d);
    @(negedge clk);
    rx2.din_valid = v;
    rx2.din       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(input int i);
    step1(1'b1, vecs[i].din);
    chk($sformatf("vec%0d error", i),   error1, vecs[i].exp_error);
    chk($sformatf("vec%0d locked", i),  locked1, vecs[i].exp_locked);
    chk($sformatf("vec%0d state", i),   state1, vecs[i].exp_state);
    chk($sformatf("vec%0d err_cnt", i), errc1, vecs[i].exp_err_cnt);
    chk($sformatf("vec%0d bit_cnt", i), bitc1, vecs[i].exp_bit_cnt);
  endtask

  initial begin
    // Single-bit slip on a locked counter, then a burst that forces unlock (counters cleared in between).
    vecs[0] = '{8'h3F, 1'b1, 1'b1, 2'd2, 32'd1, 32'd1};
    vecs[1] = '{8'h38, 1'b1, 1'b1, 2'd2, 32'd2, 32'd5};
    vecs[2] = '{8'h39, 1'b0, 1'b1, 2'd2, 32'd2, 32'd5};
    vecs[3] = '{8'h3A, 1'b0, 1'b1, 2'd2, 32'd2, 32'd5};
    vecs[4] = '{8'h55, 1'b1, 1'b1, 2'd2, 32'd1, 32'd5};
    vecs[5] = '{8'hAA, 1'b1, 1'b1, 2'd2, 32'd2, 32'd11};
    vecs[6] = '{8'h13, 1'b1, 1'b1, 2'd2, 32'd3, 32'd15};
    vecs[7] = '{8'h99, 1'b1, 1'b0, 2'd1, 32'd4, 32'd19};
    vecs[8] = '{8'h41, 1'b1, 1'b0, 2'd1, 32'd4, 32'd19};

    rx1.din = 8'h00; rx1.din_valid = 1'b0;
    rx2.din = 8'h00; rx2.din_valid = 1'b0;

    #12;
    chk("rst locked", locked1, 0);
    chk("rst error", error1, 0);
    chk("rst sticky", sticky1, 0);
    chk("rst word_cnt", word1, 0);
    chk("rst err_cnt", errc1, 0);
    chk("rst bit_cnt", bitc1, 0);
    chk("rst state", state1, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Counter stream; the 0x00 beat coincides with en rising and is consumed in IDLE.
    @(negedge clk);
    en1 = 1'b1; rx1.din_valid = 1'b1; rx1.din = 8'h00;
    @(posedge clk);
    #1;
    chk("t1 state seek", state1, 1);
    for (int d = 1; d <= 32; d++) begin
      step1(1'b1, 8'(d));
      chk($sformatf("t1 locked d=%0d", d), locked1, (d >= 17) ? 1 : 0);
      chk($sformatf("t1 error d=%0d", d), error1, 0);
    end
    chk("t1 word_cnt", word1, 15);
    chk("t1 err_cnt", errc1, 0);

    for (int d = 8'h21; d <= 8'h36; d++) step1(1'b1, 8'(d));
    for (int i = 0; i < 4; i++) apply_vec(i);
    chk("t2 sticky", sticky1, 1);

    @(negedge clk);
    rx1.din_valid = 1'b0; clr1 = 1'b1;
    @(posedge clk);
    #1;
    clr1 = 1'b0;
    chk("clr err_cnt", errc1, 0);
    chk("clr bit_cnt", bitc1, 0);
    chk("clr word_cnt", word1, 0);
    chk("clr sticky", sticky1, 0);
    chk("clr locked kept", locked1, 1);

    for (int i = 4; i < 9; i++) apply_vec(i);
    for (int d = 8'h42; d <= 8'h51; d++) begin
      step1(1'b1, 8'(d));
      chk($sformatf("t3 relock d=%0h", d), locked1, (d == 8'h51) ? 1 : 0);
    end
    chk("t3 err_cnt after seek", errc1, 4);

    // Mode switch to walking-one drops lock; beats arrive with 3-cycle gaps.
    @(negedge clk);
    mode1 = 2'd1; rx1.din_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("t4 mode chg state", state1, 1);
    chk("t4 mode chg locked", locked1, 0);
    for (int k = 0; k <= 20; k++) begin
      step1(1'b1, 8'(1 << (k % 8)));
      chk($sformatf("t4 locked k=%0d", k), locked1, (k >= 16) ? 1 : 0);
      if (k >= 1) chk($sformatf("t4 error k=%0d", k), error1, 0);
      for (int g = 0; g < 3; g++) step1(1'b0, 8'h00);
    end
    chk("t4 locked after gaps", locked1, 1);
    chk("t4 err_cnt", errc1, 4);

    // Asynchronous reset away from any clock edge.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5 rst locked", locked1, 0);
    chk("t5 rst state", state1, 0);
    chk("t5 rst err_cnt", errc1, 0);
    chk("t5 rst sticky", sticky1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step1(1'b0, 8'h00);
    chk("t5 seek after rst", state1, 1);
    for (int k = 0; k <= 16; k++) begin
      step1(1'b1, 8'(1 << (k % 8)));
      chk($sformatf("t5 relock k=%0d", k), locked1, (k == 16) ? 1 : 0);
    end
    chk("t5 word_cnt", word1, 0);

    // Narrow counters: saturation and clamp, then clr racing a mismatch.
    en1 = 1'b0;
    @(negedge clk);
    en2 = 1'b1;
    @(posedge clk);
    #1;
    chk("t6 seek", state2, 1);
    for (int i = 1; i <= 16; i++) begin
      step2(1'b1, 8'hA5);
      chk($sformatf("t6 lock i=%0d", i), locked2, (i == 16) ? 1 : 0);
    end
    for (int i = 1; i <= 20; i++) begin
      step2(1'b1, 8'h5A);
      chk($sformatf("t6 err_cnt i=%0d", i), errc2, (i > 15) ? 15 : i);
      chk($sformatf("t6 bit_cnt i=%0d", i), bitc2, (i == 1) ? 8 : 15);
      chk($sformatf("t6 word_cnt i=%0d", i), word2, (i > 15) ? 15 : i);
    end
    chk("t6 locked held", locked2, 1);
    chk("t6 error", error2, 1);
    chk("t6 sticky", sticky2, 1);
    @(negedge clk);
    clr2 = 1'b1; rx2.din_valid = 1'b1; rx2.din = 8'h5A;
    @(posedge clk);
    #1;
    clr2 = 1'b0;
    chk("t6 clr err_cnt", errc2, 0);
    chk("t6 clr bit_cnt", bitc2, 0);
    chk("t6 clr word_cnt", word2, 0);
    chk("t6 clr sticky", sticky2, 0);
    chk("t6 clr error kept", error2, 1);
    step2(1'b1, 8'hA5);
    chk("t6 post word_cnt", word2, 1);
    chk("t6 post error", error2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
